// File: rtl/farmer_game_ctrl_if.sv
// Move/undo command channel between the player front end and farmer_game_ctrl.
// The master issues move or undo requests. The slave (the controller) answers with move_ready.
interface farmer_game_ctrl_if;
   logic       move_valid;
   logic [1:0] move_sel;
   logic       move_ready;
   logic       undo_valid;

   modport master (
      output move_valid,
      output move_sel,
      output undo_valid,
      input  move_ready
   );

   modport slave (
      input  move_valid,
      input  move_sel,
      input  undo_valid,
      output move_ready
   );
endinterface

// File: rtl/farmer_game_ctrl.sv
// farmer_game_ctrl: sequential controller for the farmer/fox/goat/beans puzzle.
// It holds the bank of each item as pos = {f,x,g,b}, checks that each move is legal,
// and counts moves against a budget. It reads the external safety checker's eaten flag
// during a one-cycle CHECK state, which decides between WIN, LOSE and a return to PLAY.
// Optional feature: define FARMER_UNDO_EN to add a one-level undo of the last move.
module farmer_game_ctrl #(
   parameter int unsigned CNT_W     = 5,
   parameter int unsigned MAX_MOVES = 15
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               restart,
   farmer_game_ctrl_if.slave  cmd,
   input  logic               e_in,
   output logic [3:0]         pos,
   output logic [CNT_W-1:0]   move_count,
   output logic [1:0]         state,
   output logic               win,
   output logic               lose,
   output logic               illegal
);

   typedef enum logic [1:0] {
      ST_PLAY  = 2'd0,
      ST_CHECK = 2'd1,
      ST_WIN   = 2'd2,
      ST_LOSE  = 2'd3
   } state_e;

   localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_MOVES);

   state_e           state_q, state_d;
   logic [3:0]       pos_q, pos_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             illegal_q, illegal_d;

   logic [1:0]       pidx;
   logic [3:0]       toggle_mask;
   logic             move_legal;

`ifdef FARMER_UNDO_EN
   logic [3:0]       hist_q, hist_d;
   logic             hist_v_q, hist_v_d;
`else
   logic             unused_undo;
   assign unused_undo = cmd.undo_valid;
`endif

   // Passenger bit index in pos. For sel 0 the index lands on f itself, so the
   // mask and the legality test need no special case for the farmer crossing alone.
   always_comb begin
      pidx        = 2'd3 - cmd.move_sel;
      toggle_mask = 4'b1000 | (4'b0001 << pidx);
      move_legal  = (pos_q[pidx] == pos_q[3]);
   end

   // Next-state logic: restart first, then the per-state rules
   always_comb begin
      state_d   = state_q;
      pos_d     = pos_q;
      cnt_d     = cnt_q;
      illegal_d = 1'b0;
`ifdef FARMER_UNDO_EN
      hist_d    = hist_q;
      hist_v_d  = hist_v_q;
`endif
      if (restart) begin
         state_d = ST_PLAY;
         pos_d   = '0;
         cnt_d   = '0;
`ifdef FARMER_UNDO_EN
         hist_d   = '0;
         hist_v_d = 1'b0;
`endif
      end else begin
         unique case (state_q)
            ST_PLAY: begin
`ifdef FARMER_UNDO_EN
               if (cmd.undo_valid) begin
                  if (hist_v_q) begin
                     pos_d    = hist_q;
                     cnt_d    = cnt_q - 1'b1;
                     hist_v_d = 1'b0;
                  end else begin
                     illegal_d = 1'b1;
                  end
               end else
`endif
               if (cmd.move_valid) begin
                  if (move_legal) begin
                     pos_d   = pos_q ^ toggle_mask;
                     cnt_d   = cnt_q + 1'b1;
                     state_d = ST_CHECK;
`ifdef FARMER_UNDO_EN
                     hist_d   = pos_q;
                     hist_v_d = 1'b1;
`endif
                  end else begin
                     illegal_d = 1'b1;
                  end
               end
            end
            ST_CHECK: begin
               if (e_in)                 state_d = ST_LOSE;
               else if (pos_q == 4'b1111) state_d = ST_WIN;
               else if (cnt_q == MAX_CNT) state_d = ST_LOSE;
               else                       state_d = ST_PLAY;
            end
            default: ;
         endcase
      end
   end

   // State register with asynchronous active-low reset
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= ST_PLAY;
         pos_q     <= '0;
         cnt_q     <= '0;
         illegal_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         pos_q     <= pos_d;
         cnt_q     <= cnt_d;
         illegal_q <= illegal_d;
      end
   end

`ifdef FARMER_UNDO_EN
   // One-level undo history register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         hist_q   <= '0;
         hist_v_q <= 1'b0;
      end else begin
         hist_q   <= hist_d;
         hist_v_q <= hist_v_d;
      end
   end
`endif

   assign cmd.move_ready = (state_q == ST_PLAY);
   assign pos            = pos_q;
   assign move_count     = cnt_q;
   assign state          = state_q;
   assign win            = (state_q == ST_WIN);
   assign lose           = (state_q == ST_LOSE);
   assign illegal        = illegal_q;

endmodule
